// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two word generators.
// Define ARB_STATS_EN to add saturating per-requester accept counters on cnt0/cnt1.
module fifo_wr_arbiter #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    input  logic          full,
    output logic          wrreq,
    output logic [DW-1:0] data,
    output logic [1:0]    grant,
    output logic [7:0]    cnt0,
    output logic [7:0]    cnt1
);

    // One-hot owner encoding so the state register drives grant directly.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] burst_cnt;
    logic [3:0] burst_cnt_nxt;
    logic       last_owner;
    logic       last_owner_nxt;

    logic own0;
    logic own1;
    logic cur_req;
    logic other_req;
    logic accept;
    logic burst_done;
    logic burst_end;

    assign own0      = (state == OWN0);
    assign own1      = (state == OWN1);
    assign cur_req   = (own0 & req0) | (own1 & req1);
    assign other_req = (own0 & req1) | (own1 & req0);

    // A word offered while RST is high is neither written nor acknowledged.
    assign accept = cur_req & ~full & ~RST;

    assign wrreq = accept;
    assign ack0  = own0 & accept;
    assign ack1  = own1 & accept;
    assign grant = state;

    always_comb begin
        data = '0;
        if (own0) begin
            data = data0;
        end else if (own1) begin
            data = data1;
        end
    end

    assign burst_done = accept && ((burst_cnt + 4'd1) == BURST_MAX);
    assign burst_end  = (own0 | own1) && (burst_done || !cur_req);

    always_comb begin
        state_nxt      = state;
        burst_cnt_nxt  = burst_cnt;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (burst_end) begin
                    burst_cnt_nxt  = 4'd0;
                    last_owner_nxt = own1;
                    // Hand straight over to a waiting peer so no idle bubble appears.
                    if (other_req) begin
                        state_nxt = own0 ? OWN1 : OWN0;
                    end else if (cur_req) begin
                        state_nxt = state;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (accept) begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                burst_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            burst_cnt  <= 4'd0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

`ifdef ARB_STATS_EN
    logic [7:0] stat0;
    logic [7:0] stat1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat0 <= 8'd0;
            stat1 <= 8'd0;
        end else begin
            if (ack0 && (stat0 != 8'hFF)) begin
                stat0 <= stat0 + 8'd1;
            end
            if (ack1 && (stat1 != 8'hFF)) begin
                stat1 <= stat1 + 8'd1;
            end
        end
    end

    assign cnt0 = stat0;
    assign cnt1 = stat1;
`else
    assign cnt0 = 8'd0;
    assign cnt1 = 8'd0;
`endif

endmodule
